// File: rtl/wbu_pkg.sv
// wbu_pkg: shared types and constants for the writeback unit.
//   DATA_W      register data width, taken from the project-wide `DATA_WIDTH
//   REG_ADDR_W  register address width (5)
//   REG_NUM     number of integer registers (32)
//   WBU_DEPTH   default LSU result FIFO depth
//   wbEntry_t   one pending register write (destination + data)
//   wbSrc_e     which source feeds the output register in a given cycle
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package wbu_pkg;

    localparam int DATA_W     = `DATA_WIDTH;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;
    localparam int WBU_DEPTH  = 2;
    localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wbEntry_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_EXU    = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wbSrc_e;

    // LSU-origin writes are the only ones that retire a scoreboard bit.
    function automatic logic isLsuSrc(input wbSrc_e src);
        return (src == SRC_FIFO) || (src == SRC_BYPASS);
    endfunction

endpackage

// File: rtl/wbu_fifo.sv
// wbu_fifo: synchronous FIFO holding LSU results until the write port is free.
//   clk, rstn   clock, asynchronous active-low reset (empties the FIFO)
//   push_i      write wdata_i (ignored while full)
//   wdata_i     entry to store
//   pop_i       drop the head entry (ignored while empty)
//   rdata_o     current head entry (valid while !empty_o)
//   full_o      DEPTH entries held, from the registered count only
//   empty_o     no entries held
module wbu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign rdata_o = mem_q[rdPtr_q];

    // Storage carries no reset: an entry is only read after it was written,
    // and the pointers/count below define what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap explicitly at DEPTH; the count tracks occupancy so full
    // and empty never need pointer comparison tricks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= (wrPtr_q == PTR_W'(DEPTH-1)) ? '0 : wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= (rdPtr_q == PTR_W'(DEPTH-1)) ? '0 : rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wbu.sv
// wbu: writeback unit, the single initiator of register-file writes.
//   clk, rstn                 clock, asynchronous active-low reset
//   exu_valid_i/rd_i/data_i   single-cycle EXU result, always accepted
//   lsu_valid_i/rd_i/data_i   multi-cycle LSU result, handshaked with lsu_ready_o
//   lsu_ready_o               LSU result FIFO has room (0 while in reset)
//   issue_valid_i/rd_i        IDU issues a load to rd this cycle
//   rs1/rs2/rd_addr_i         IDU addresses checked against outstanding loads
//   stall_o                   IDU must hold its current instruction
//   rd_addr/rd_data/wen_o_wbu_ram  registered register-file write port
// Optional feature macro: WBU_LSU_BYPASS_EN lets an LSU result skip an empty
// FIFO and reach the write port one cycle earlier.
module wbu
    import wbu_pkg::*;
#(
    parameter int DEPTH = WBU_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  exu_valid_i,
    input  logic [REG_ADDR_W-1:0] exu_rd_i,
    input  logic [DATA_W-1:0]     exu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_rd_i,
    input  logic [DATA_W-1:0]     lsu_data_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    output logic                  stall_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o_wbu_ram,
    output logic [DATA_W-1:0]     rd_data_o_wbu_ram,
    output logic                  wen_o_wbu_ram
);

    logic [REG_NUM-1:0]    scoreBoard_q;
    logic [REG_NUM-1:0]    scoreBoard_d;
    logic [REG_ADDR_W-1:0] wbAddr_q;
    logic [DATA_W-1:0]     wbData_q;
    logic                  wbEn_q;
    wbSrc_e                src;
    wbEntry_t              selEntry;
    wbEntry_t              fifoHead;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  fifoPush;
    logic                  fifoPop;
    logic                  lsuXfer;

    // Ready comes from the registered FIFO count, so a pop in the same cycle
    // does not raise it; it is also held low while reset is asserted.
    assign lsu_ready_o = rstn & ~fifoFull;
    assign lsuXfer     = lsu_valid_i & lsu_ready_o;

    // Fixed-priority source selection: EXU always wins, then the FIFO head.
    // With the bypass build an LSU transfer may use an otherwise idle port,
    // but only when the FIFO is empty so ordering is preserved.
    always_comb begin
        src      = SRC_NONE;
        selEntry = fifoHead;
        if (exu_valid_i) begin
            src      = SRC_EXU;
            selEntry = '{rd: exu_rd_i, data: exu_data_i};
        end else if (!fifoEmpty) begin
            src      = SRC_FIFO;
            selEntry = fifoHead;
        end
`ifdef WBU_LSU_BYPASS_EN
        else if (lsuXfer) begin
            src      = SRC_BYPASS;
            selEntry = '{rd: lsu_rd_i, data: lsu_data_i};
        end
`endif
    end

    assign fifoPush = lsuXfer & (src != SRC_BYPASS);
    assign fifoPop  = (src == SRC_FIFO);

    wbu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifoPush),
        .wdata_i ({lsu_rd_i, lsu_data_i}),
        .pop_i   (fifoPop),
        .rdata_o (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Scoreboard next state: the retiring LSU write clears its bit first so a
    // same-cycle issue to the same register re-sets it. x0 never stalls.
    always_comb begin
        scoreBoard_d = scoreBoard_q;
        if (isLsuSrc(src)) begin
            scoreBoard_d[selEntry.rd] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            scoreBoard_d[issue_rd_i] = 1'b1;
        end
        scoreBoard_d[0] = 1'b0;
    end

    // Output register and scoreboard share an edge, so stall_o drops in the
    // same cycle wen_o is high and register-file write-through covers the read.
    // A result to x0 is consumed without raising the write enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbEn_q       <= 1'b0;
            wbAddr_q     <= '0;
            wbData_q     <= '0;
            scoreBoard_q <= '0;
        end else begin
            wbEn_q       <= (src != SRC_NONE) && (selEntry.rd != '0);
            scoreBoard_q <= scoreBoard_d;
            if (src != SRC_NONE) begin
                wbAddr_q <= selEntry.rd;
                wbData_q <= selEntry.data;
            end
        end
    end

    assign stall_o = scoreBoard_q[rs1_addr_i] | scoreBoard_q[rs2_addr_i]
                   | scoreBoard_q[rd_addr_i];

    assign rd_addr_o_wbu_ram = wbAddr_q;
    assign rd_data_o_wbu_ram = wbData_q;
    assign wen_o_wbu_ram     = wbEn_q;

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed self-checking bench for wbu. Expected register-file writes
// are queued as stimulus is issued; a negedge monitor pops and compares every
// write the DUT performs. Handshake, stall and reset behaviour are checked
// directly against hand-computed values.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_wbu;
    import wbu_pkg::*;

    logic                  clk;
    logic                  rstn;
    logic                  exuValid;
    logic [REG_ADDR_W-1:0] exuRd;
    logic [DATA_W-1:0]     exuData;
    logic                  lsuValid;
    logic                  lsuReady;
    logic [REG_ADDR_W-1:0] lsuRd;
    logic [DATA_W-1:0]     lsuData;
    logic                  issueValid;
    logic [REG_ADDR_W-1:0] issueRd;
    logic [REG_ADDR_W-1:0] rs1Addr;
    logic [REG_ADDR_W-1:0] rs2Addr;
    logic [REG_ADDR_W-1:0] rdAddr;
    logic                  stall;
    logic [REG_ADDR_W-1:0] wbAddr;
    logic [DATA_W-1:0]     wbData;
    logic                  wen;

    int       vectors;
    int       miscompares;
    wbEntry_t expQ[$];

    wbu #(.DEPTH(2)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .exu_valid_i       (exuValid),
        .exu_rd_i          (exuRd),
        .exu_data_i        (exuData),
        .lsu_valid_i       (lsuValid),
        .lsu_ready_o       (lsuReady),
        .lsu_rd_i          (lsuRd),
        .lsu_data_i        (lsuData),
        .issue_valid_i     (issueValid),
        .issue_rd_i        (issueRd),
        .rs1_addr_i        (rs1Addr),
        .rs2_addr_i        (rs2Addr),
        .rd_addr_i         (rdAddr),
        .stall_o           (stall),
        .rd_addr_o_wbu_ram (wbAddr),
        .rd_data_o_wbu_ram (wbData),
        .wen_o_wbu_ram     (wen)
    );

    // Free-running 10 ns clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic exuV, input logic [4:0] eRd,
                                 input logic [DATA_W-1:0] eData,
                                 input logic lsuV, input logic [4:0] lRd,
                                 input logic [DATA_W-1:0] lData,
                                 input logic issV, input logic [4:0] iRd);
        exuValid   = exuV;
        exuRd      = eRd;
        exuData    = eData;
        lsuValid   = lsuV;
        lsuRd      = lRd;
        lsuData    = lData;
        issueValid = issV;
        issueRd    = iRd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [4:0] rd, input logic [DATA_W-1:0] data);
        wbEntry_t e;
        e.rd   = rd;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Monitor: every write the DUT performs must match the next queued one.
    always @(negedge clk) begin
        if (rstn && wen) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write",
                         wbAddr, wbData);
            end else begin
                wbEntry_t e;
                e = expQ.pop_front();
                checkOutput("wb_write", 64'({wbAddr, wbData}), 64'({e.rd, e.data}));
            end
        end
    end

    initial begin
        logic readyBefore;
        logic lsuV;
        int   lsuIdx;

        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        rs1Addr     = '0;
        rs2Addr     = '0;
        rdAddr      = '0;
        idle();

        // Reset state, then release between edges
        #12;
        checkOutput("reset_wen", 64'(wen), 64'd0);
        checkOutput("reset_ready", 64'(lsuReady), 64'd0);
        checkOutput("reset_addr", 64'(wbAddr), 64'd0);
        checkOutput("reset_data", 64'(wbData), 64'd0);
        #1 rstn = 1'b1;
        step();
        checkOutput("post_reset_wen", 64'(wen), 64'd0);
        checkOutput("post_reset_stall", 64'(stall), 64'd0);
        checkOutput("post_reset_ready", 64'(lsuReady), 64'd1);

        // EXU write to x5
        $display("[TB] EXU write rd=5");
        applyStimulus(1'b1, 5'd5, 'h1234, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        pushExp(5'd5, 'h1234);
        step();
        idle();
        checkOutput("exu_wen", 64'(wen), 64'd1);
        step();
        checkOutput("exu_wen_one_cycle", 64'(wen), 64'd0);

        // EXU write to x0 is dropped
        $display("[TB] EXU write rd=0");
        applyStimulus(1'b1, 5'd0, 'hFFFF, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        step();
        idle();
        checkOutput("exu_rd0_wen", 64'(wen), 64'd0);

        // Load to x7: stall until the LSU result writes back
        $display("[TB] load hazard rd=7");
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
        step();
        idle();
        rs1Addr = 5'd7;
        #1;
        checkOutput("hazard_stall_set", 64'(stall), 64'd1);
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd7, 'hAA, 1'b0, 5'd0);
        pushExp(5'd7, 'hAA);
        step();
        idle();
`ifdef WBU_LSU_BYPASS_EN
        checkOutput("lsu_bypass_wen", 64'(wen), 64'd1);
        checkOutput("lsu_bypass_stall", 64'(stall), 64'd0);
`else
        checkOutput("lsu_n1_wen", 64'(wen), 64'd0);
        checkOutput("lsu_n1_stall", 64'(stall), 64'd1);
        step();
        checkOutput("lsu_n2_wen", 64'(wen), 64'd1);
        checkOutput("lsu_n2_stall", 64'(stall), 64'd0);
`endif
        rs1Addr = 5'd0;
        step();

        // EXU busy for 6 cycles while 3 LSU results arrive into a 2-deep FIFO
        $display("[TB] FIFO backpressure and drain");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'(10 + i));
            step();
        end
        idle();
        for (int i = 0; i < 6; i++) pushExp(5'(20 + i), DATA_W'(32'h100 + i));
        for (int i = 0; i < 3; i++) pushExp(5'(10 + i), DATA_W'(32'hA0 + i));
        lsuIdx = 0;
        for (int c = 0; c < 12; c++) begin
            lsuV = (lsuIdx < 3);
            applyStimulus(c < 6, 5'(20 + c), DATA_W'(32'h100 + c),
                          lsuV, 5'(10 + lsuIdx), DATA_W'(32'hA0 + lsuIdx), 1'b0, 5'd0);
            readyBefore = lsuReady;
            if (c == 2) checkOutput("ready_low_after_2", 64'(readyBefore), 64'd0);
            if (c == 6) checkOutput("ready_low_at_first_pop", 64'(readyBefore), 64'd0);
            if (c == 7) checkOutput("ready_high_after_pop", 64'(readyBefore), 64'd1);
            step();
            if (lsuV && readyBefore) lsuIdx++;
            checkOutput($sformatf("drain_wen_c%0d", c), 64'(wen), 64'(c <= 8));
        end
        idle();
        checkOutput("lsu_accepts", 64'(lsuIdx), 64'd3);
        rs1Addr = 5'd10;
        rs2Addr = 5'd11;
        rdAddr  = 5'd12;
        #1;
        checkOutput("drain_stall_cleared", 64'(stall), 64'd0);
        rs1Addr = '0;
        rs2Addr = '0;
        rdAddr  = '0;

        // Same-cycle issue and retire of x9: set wins
        $display("[TB] set/clear collision rd=9");
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9);
        step();
`ifdef WBU_LSU_BYPASS_EN
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd9, 'h99, 1'b1, 5'd9);
        pushExp(5'd9, 'h99);
        step();
`else
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd9, 'h99, 1'b0, 5'd0);
        pushExp(5'd9, 'h99);
        step();
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9);
        step();
`endif
        idle();
        rs2Addr = 5'd9;
        #1;
        checkOutput("collision_wen", 64'(wen), 64'd1);
        checkOutput("collision_stall", 64'(stall), 64'd1);
        rs2Addr = '0;
        step();

        // Reset while the FIFO is full and the EXU keeps the port busy
        $display("[TB] reset mid-drain");
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd13);
        step();
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd14);
        step();
        applyStimulus(1'b1, 5'd21, 'h210, 1'b1, 5'd13, 'hD3, 1'b0, 5'd0);
        pushExp(5'd21, 'h210);
        step();
        applyStimulus(1'b1, 5'd22, 'h220, 1'b1, 5'd14, 'hD4, 1'b0, 5'd0);
        pushExp(5'd22, 'h220);
        step();
        applyStimulus(1'b1, 5'd23, 'h230, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        step();
        checkOutput("pre_reset_wen", 64'(wen), 64'd1);
        checkOutput("pre_reset_ready", 64'(lsuReady), 64'd0);
        #1 rstn = 1'b0;
        #1;
        checkOutput("async_reset_wen", 64'(wen), 64'd0);
        checkOutput("async_reset_ready", 64'(lsuReady), 64'd0);
        idle();
        step();
        step();
        #2 rstn = 1'b1;
        #1;
        checkOutput("rerelease_ready", 64'(lsuReady), 64'd1);
        rs1Addr = 5'd13;
        rs2Addr = 5'd14;
        rdAddr  = 5'd9;
        #1;
        checkOutput("rerelease_stall", 64'(stall), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("rerelease_wen_%0d", i), 64'(wen), 64'd0);
        end
        rs1Addr = '0;
        rs2Addr = '0;
        rdAddr  = '0;
        step();

        checkOutput("exp_queue_empty", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wbu.md
# wbu

Writeback unit: the write-side initiator for the 32-entry integer register file. Merges single-cycle EXU results and handshaked multi-cycle LSU results into the register file's single write port (rd_addr / rd_data / wen). Keeps a pending-destination scoreboard so the IDU stalls on hazards against outstanding loads. Sits between EXU/LSU and the register file, with a hazard output to the IDU.

## Interface
- DEPTH, 2: LSU result FIFO entries (power of two, ≥2)
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- exu_valid_i  in  1  EXU result valid; always accepted
- exu_rd_i  in  5  EXU destination
- exu_data_i  in  `DATA_WIDTH  EXU result
- lsu_valid_i  in  1  LSU result valid
- lsu_ready_o  out  1  LSU result accepted (FIFO not full)
- lsu_rd_i  in  5  LSU destination
- lsu_data_i  in  `DATA_WIDTH  LSU result
- issue_valid_i  in  1  IDU issues a load this cycle
- issue_rd_i  in  5  destination of the issued load
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  IDU operand/destination addresses for hazard check
- stall_o  out  1  IDU must hold the current instruction
- rd_addr_o_wbu_ram  out  5  register-file write address
- rd_data_o_wbu_ram  out  `DATA_WIDTH  register-file write data
- wen_o_wbu_ram  out  1  register-file write enable

## Operation
- Reset: wen_o=0, rd_addr_o=0, rd_data_o=0, FIFO empty, all scoreboard bits 0. lsu_ready_o=1 after reset is released (0 while rstn low).
- LSU handshake: transfer on lsu_valid_i & lsu_ready_o; the entry is pushed into the FIFO. lsu_ready_o = !full (registered count; a same-cycle pop does not raise ready).
- Arbitration per cycle, fixed priority: EXU > FIFO head. When exu_valid_i=1, the EXU result loads the output register. Otherwise a non-empty FIFO pops its head into the output register. The FIFO cannot starve indefinitely only if EXU idles; no fairness guarantee.
- Output register: wen_o is asserted for exactly one cycle per selected result. A result with rd=0 is consumed (FIFO popped, EXU dropped) but wen_o stays 0.
- Scoreboard: 32 bits; bit 0 is hardwired 0.
  - Set on issue_valid_i when issue_rd_i≠0.
  - Cleared when an LSU-origin entry is popped into the output register.
  - Simultaneous set and clear of the same bit: set wins.
- stall_o (combinational) = sb[rs1_addr_i] | sb[rs2_addr_i] | sb[rd_addr_i]. The rd term prevents WAW against an outstanding load. It does not gate exu_valid_i; the IDU is responsible for honoring it.
- Illegal: lsu_valid_i for an rd whose bit is clear. This is not detected and the write proceeds.

## Timing
- EXU: result presented at cycle N gives wen_o at N+1.
- LSU (default): accepted at N gives FIFO at N+1, and wen_o at N+2 at the earliest (EXU-free cycle).
- Scoreboard clears on the same edge that asserts wen_o. stall_o drops in the cycle wen_o is high, so the register file's write-through forwarding covers the IDU read.
- Full FIFO with continuous EXU: lsu_ready_o stays 0 until an EXU-idle cycle pops. Ready rises one cycle after that pop.
- Reset asserted mid-operation: FIFO contents and scoreboard discarded immediately and wen_o forced 0 asynchronously.

## Configuration
- WBU_LSU_BYPASS_EN defined:
  - When the FIFO is empty, exu_valid_i=0, and an LSU transfer occurs, the result goes straight into the output register (wen_o at N+1) and is not pushed.
  - Scoreboard clears on that edge.
- WBU_LSU_BYPASS_EN undefined: all LSU results pass through the FIFO (minimum latency 2).

## Structure
- Shared package/defines: `DATA_WIDTH (existing), REG_ADDR_W=5, REG_NUM=32, WBU default DEPTH.
- Sub-module wbu_fifo: synchronous FIFO with parameterized DEPTH and width 5+`DATA_WIDTH, providing push/pop/full/empty, async active-low reset, and pointer wrap at DEPTH.
- Scoreboard, arbiter and output register live in wbu.

## Test plan
- Reset release → wen_o=0, stall_o=0, lsu_ready_o=1. EXU rd=5 data=0x1234 → next cycle wen_o=1, addr=5, data=0x1234.
- EXU rd=0 data=0xFFFF → wen_o stays 0 the next cycle.
- Issue load rd=7, then IDU rs1=7 → stall_o=1. LSU returns rd=7 data=0xAA → wen_o at N+2 (N+1 with bypass), stall_o=0 that cycle.
- EXU valid every cycle for 6 cycles while LSU pushes 3 results (DEPTH=2):
  - lsu_ready_o=0 after 2 accepts.
  - After EXU stops, FIFO drains in order with 1 write/cycle.
  - No result is lost or duplicated.
- Same-cycle issue rd=9 and LSU-origin pop for rd=9 → bit 9 remains set and stall_o=1 for rs2=9.
- Assert rstn mid-drain with FIFO full → wen_o=0 at once. After release: FIFO empty, all scoreboard bits 0, lsu_ready_o=1.
